// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: shared types and constants for the timer front-end controller.
// Mode states, command codes, key slot indices, digit limits and reset presets.
package key_cmd_pkg;

  // Mode FSM encoding; the numeric values are visible on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SET    = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  // Winner of the per-cycle priority encoder.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_PAUSE = 3'd2,
    CMD_UP    = 3'd3,
    CMD_DOWN  = 3'd4,
    CMD_TEN   = 3'd5,
    CMD_ONE   = 3'd6
  } cmd_t;

  // Slot of each button inside the packed press-event vector.
  localparam int NUM_KEYS  = 6;
  localparam int KEY_UP    = 0;  // key0
  localparam int KEY_DOWN  = 1;  // key1
  localparam int KEY_PAUSE = 2;  // key2
  localparam int KEY_TEN   = 3;  // key4
  localparam int KEY_ONE   = 4;  // key5
  localparam int KEY_LOAD  = 5;  // key6

  // Digit limits and the 15 s preset applied at reset.
  localparam logic [3:0] TEN_MAX = 4'd5;
  localparam logic [3:0] ONE_MAX = 4'd9;
  localparam logic [3:0] TEN_RST = 4'd1;
  localparam logic [3:0] ONE_RST = 4'd5;

  // Wrapping increment; anything at or above the limit returns to zero so a
  // digit can never leave its legal range.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and one-cycle press
// event for a single active-low button. With KEY_AUTOREPEAT_EN defined, a held
// key also emits repeat events after HOLD_CYCLES and then every REPEAT_CYCLES.
module key_debounce #(
  parameter int DB_CYCLES     = 4
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 200,
  parameter bit REPEAT_EN     = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic          db, db_d;
  logic [CW-1:0] cnt;
  logic          press_q;

  // Bring the asynchronous button into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed for DB_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db  <= 1'b1;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered falling-edge detect on the debounced level: one pulse per press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_d    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      db_d    <= db;
      press_q <= db_d & ~db;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rep_phase;
  logic          rep_q;

  // Hold/repeat timer: runs while the key stays down, cleared the moment the
  // synchronized input reads released so repeats stop without waiting for debounce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!REPEAT_EN || db || s2) begin
        rcnt      <= '0;
        rep_phase <= 1'b0;
      end else if (rcnt == (rep_phase ? RW'(REPEAT_CYCLES) : RW'(HOLD_CYCLES))) begin
        rcnt      <= RW'(1);
        rep_phase <= 1'b1;
        rep_q     <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  assign press = press_q | rep_q;
`else
  assign press = press_q;
`endif

endmodule

// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl: button front-end for timer_60s. Debounces six active-low keys,
// picks one event per cycle by fixed priority and runs the IDLE/SET/RUN/PAUSED
// mode FSM that drives en, pause, dir_up, the preset digits and the load strobe.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat on key4/key5).
// The press events are single-cycle strobes with no back-pressure: the FSM
// consumes at most one per cycle and any simultaneous lower-priority strobe is lost.
module key_cmd_ctrl
  import key_cmd_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 200
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  input  logic       key4,
  input  logic       key5,
  input  logic       key6,
  input  logic       done,
  output logic       en,
  output logic       pause,
  output logic       dir_up,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       load,
  output logic [1:0] state
);

  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  // Every timing parameter must resolve to at least one clock cycle.
  if (DB_CYCLES < 1 || HOLD_MS < 1 || REPEAT_MS < 1) begin : g_bad_cfg
    $error("key_cmd_ctrl: timing parameters must resolve to at least one cycle");
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_CYCLES   = CLK_HZ / 1000 * HOLD_MS;
  localparam int REPEAT_CYCLES = CLK_HZ / 1000 * REPEAT_MS;
`endif

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] press;
  cmd_t                cmd;
  state_t              st;

  always_comb begin
    raw_keys            = '1;
    raw_keys[KEY_UP]    = key0;
    raw_keys[KEY_DOWN]  = key1;
    raw_keys[KEY_PAUSE] = key2;
    raw_keys[KEY_TEN]   = key4;
    raw_keys[KEY_ONE]   = key5;
    raw_keys[KEY_LOAD]  = key6;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES     (DB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     ((g == KEY_TEN) || (g == KEY_ONE))
`endif
    ) u_db (
      .clk     (clk_50M),
      .rst_n   (rst_n),
      .key_raw (raw_keys[g]),
      .press   (press[g])
    );
  end

  // Priority encoder: key6 > key2 > key0 > key1 > key4 > key5.
  always_comb begin
    cmd = CMD_NONE;
    if      (press[KEY_LOAD])  cmd = CMD_LOAD;
    else if (press[KEY_PAUSE]) cmd = CMD_PAUSE;
    else if (press[KEY_UP])    cmd = CMD_UP;
    else if (press[KEY_DOWN])  cmd = CMD_DOWN;
    else if (press[KEY_TEN])   cmd = CMD_TEN;
    else if (press[KEY_ONE])   cmd = CMD_ONE;
  end

  // Mode FSM; en/pause are written alongside every state change so they always
  // equal the decode of the registered state. load defaults low each cycle.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      en     <= 1'b0;
      pause  <= 1'b0;
      dir_up <= 1'b1;
      load   <= 1'b0;
      ten    <= TEN_RST;
      one    <= ONE_RST;
    end else begin
      load <= 1'b0;
      case (st)
        ST_IDLE, ST_SET: begin
          case (cmd)
            CMD_LOAD: begin
              st   <= ST_IDLE;
              load <= 1'b1;
            end
            CMD_UP: begin
              st     <= ST_RUN;
              en     <= 1'b1;
              dir_up <= 1'b1;
              load   <= 1'b1;
            end
            CMD_DOWN: begin
              st     <= ST_RUN;
              en     <= 1'b1;
              dir_up <= 1'b0;
              load   <= 1'b1;
            end
            CMD_TEN: begin
              st  <= ST_SET;
              ten <= digit_inc(ten, TEN_MAX);
            end
            CMD_ONE: begin
              st  <= ST_SET;
              one <= digit_inc(one, ONE_MAX);
            end
            default: ;
          endcase
        end
        ST_RUN: begin
          if (done) begin
            st <= ST_IDLE;
            en <= 1'b0;
          end else begin
            case (cmd)
              CMD_LOAD: begin
                st <= ST_IDLE;
                en <= 1'b0;
              end
              CMD_PAUSE: begin
                st    <= ST_PAUSED;
                pause <= 1'b1;
              end
              CMD_UP: begin
                dir_up <= 1'b1;
                load   <= 1'b1;
              end
              CMD_DOWN: begin
                dir_up <= 1'b0;
                load   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_PAUSED: begin
          case (cmd)
            CMD_LOAD: begin
              st    <= ST_IDLE;
              en    <= 1'b0;
              pause <= 1'b0;
            end
            CMD_PAUSE: begin
              st    <= ST_RUN;
              pause <= 1'b0;
            end
            default: ;
          endcase
        end
        default: begin
          st    <= ST_IDLE;
          en    <= 1'b0;
          pause <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// tb_key_cmd_ctrl: directed scenarios plus random button/done/reset traffic,
// checked every cycle against a behavioural model of the controller.
module tb_key_cmd_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int DB          = 4;
  localparam int ORD[6]      = '{6, 2, 0, 1, 4, 5};
  localparam int KL[6]       = '{0, 1, 2, 4, 5, 6};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       done  = 1'b0;
  logic [6:0] kraw  = 7'h7f;

  logic       en, pause, dir_up, load;
  logic [3:0] ten, one;
  logic [1:0] state;

  key_cmd_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .HOLD_MS     (500),
    .REPEAT_MS   (200)
  ) dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .key0    (kraw[0]),
    .key1    (kraw[1]),
    .key2    (kraw[2]),
    .key4    (kraw[4]),
    .key5    (kraw[5]),
    .key6    (kraw[6]),
    .done    (done),
    .en      (en),
    .pause   (pause),
    .dir_up  (dir_up),
    .ten     (ten),
    .one     (one),
    .load    (load),
    .state   (state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: the debounced level flips once the DB raw samples taken two to
  // DB+1 edges ago all disagree with it; a fall becomes an event seen by the
  // mode logic two edges later.
  logic [15:0] hist [0:6];
  logic        mdb  [0:6];
  logic        fellp[0:6];
  logic        pv   [0:6];
  int          m_state;
  logic        m_en, m_pause, m_dir, m_load;
  int          m_ten, m_one;

  always @(posedge clk) begin
    logic            ev [0:6];
    logic [DB-1:0]   w;
    logic            diff;
    int              sel;
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        hist[i]  = '1;
        mdb[i]   = 1'b1;
        fellp[i] = 1'b0;
        pv[i]    = 1'b0;
      end
      m_state = 0; m_en = 0; m_pause = 0; m_dir = 1; m_load = 0;
      m_ten = 1; m_one = 5;
    end else begin
      for (int i = 0; i < 7; i++) begin
        ev[i]    = pv[i];
        pv[i]    = fellp[i];
        hist[i]  = {hist[i][14:0], kraw[i]};
        w        = hist[i][DB+1:2];
        diff     = mdb[i] ? (w == '0) : (w == '1);
        fellp[i] = diff & mdb[i];
        if (diff) mdb[i] = ~mdb[i];
      end
      sel = -1;
      for (int j = 5; j >= 0; j--) if (ev[ORD[j]]) sel = ORD[j];
      m_load = 0;
      if (m_state == 0 || m_state == 1) begin
        if (sel == 6) begin m_state = 0; m_load = 1; end
        else if (sel == 0) begin m_state = 2; m_dir = 1; m_load = 1; end
        else if (sel == 1) begin m_state = 2; m_dir = 0; m_load = 1; end
        else if (sel == 4) begin m_state = 1; m_ten = (m_ten + 1) % 6; end
        else if (sel == 5) begin m_state = 1; m_one = (m_one + 1) % 10; end
      end else if (m_state == 2) begin
        if (done) m_state = 0;
        else if (sel == 6) m_state = 0;
        else if (sel == 2) m_state = 3;
        else if (sel == 0) begin m_dir = 1; m_load = 1; end
        else if (sel == 1) begin m_dir = 0; m_load = 1; end
      end else begin
        if (sel == 6) m_state = 0;
        else if (sel == 2) m_state = 2;
      end
      m_en    = (m_state >= 2);
      m_pause = (m_state == 3);
    end
    #1;
    check("cyc_state",  state,  m_state);
    check("cyc_en",     en,     m_en);
    check("cyc_pause",  pause,  m_pause);
    check("cyc_dir_up", dir_up, m_dir);
    check("cyc_load",   load,   m_load);
    check("cyc_ten",    ten,    m_ten);
    check("cyc_one",    one,    m_one);
  end

  // ---------------- driver tasks ----------------
  task automatic press_key(input int idx, input int len);
    @(negedge clk);
    kraw[idx] = 1'b0;
    repeat (len) @(negedge clk);
    kraw[idx] = 1'b1;
    repeat (DB + 4) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  int exp_ten[6] = '{2, 3, 4, 5, 0, 1};
  int exp_one[5] = '{6, 7, 8, 9, 0};

  initial begin
    int k1, k2, len, gap;

    // reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_en", en, 0);
    check("rst_pause", pause, 0);
    check("rst_ten", ten, 1);
    check("rst_one", one, 5);
    check("rst_dir_up", dir_up, 1);
    check("rst_state", state, 0);

    // glitch rejection
    press_key(0, 3);
    check("glitch_state", state, 0);

    // exact press latency: action on the 7th edge after the first low sample
    @(negedge clk);
    kraw[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("lat_early_state", state, 0);
    @(posedge clk);
    #1;
    check("lat_load", load, 1);
    check("lat_state", state, 2);
    check("lat_en", en, 1);
    check("lat_dir_up", dir_up, 1);
    @(posedge clk);
    #1 check("lat_load_clear", load, 0);
    @(negedge clk);
    kraw[0] = 1'b1;
    repeat (DB + 4) @(negedge clk);

    // pause toggle and done
    press_key(2, 8);
    check("pause_on", pause, 1);
    check("pause_state", state, 3);
    press_key(2, 8);
    check("pause_off", pause, 0);
    check("resume_state", state, 2);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    check("done_state", state, 0);
    check("done_en", en, 0);

    // digit wrap
    for (int i = 0; i < 6; i++) begin
      press_key(4, 8);
      check("wrap_ten", ten, exp_ten[i]);
    end
    for (int i = 0; i < 5; i++) begin
      press_key(5, 8);
      check("wrap_one", one, exp_one[i]);
    end
    check("set_state", state, 1);
    @(negedge clk);
    kraw[6] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("key6_load", load, 1);
    check("key6_ten", ten, 1);
    check("key6_one", one, 0);
    check("key6_state", state, 0);
    @(negedge clk);
    kraw[6] = 1'b1;
    repeat (DB + 4) @(negedge clk);

    // priority: key6 beats key0 in the same cycle
    @(negedge clk);
    kraw[6] = 1'b0;
    kraw[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("prio_load", load, 1);
    check("prio_state", state, 0);
    check("prio_en", en, 0);
    @(negedge clk);
    kraw[6] = 1'b1;
    kraw[0] = 1'b1;
    repeat (DB + 4) @(negedge clk);

    // reset in the middle of a count-down run
    press_key(1, 8);
    check("run_down_state", state, 2);
    check("run_down_dir", dir_up, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_state", state, 0);
    check("midrst_en", en, 0);
    check("midrst_dir_up", dir_up, 1);
    check("midrst_ten", ten, 1);
    check("midrst_one", one, 5);
    check("midrst_load", load, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic; the per-cycle model check covers everything here
    repeat (300) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
      k1  = KL[$urandom_range(0, 5)];
      k2  = ($urandom_range(0, 3) == 0) ? KL[$urandom_range(0, 5)] : k1;
      len = $urandom_range(1, 12);
      gap = $urandom_range(0, 12);
      @(negedge clk);
      kraw[k1] = 1'b0;
      kraw[k2] = 1'b0;
      repeat (len) begin
        @(negedge clk);
        done = ($urandom_range(0, 15) == 0);
      end
      kraw[k1] = 1'b1;
      kraw[k2] = 1'b1;
      repeat (gap) begin
        @(negedge clk);
        done = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      done = 1'b0;
    end

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
